e2lp_led_arbiter: RTL and testbench



---
 rtl/e2lp_led_arbiter_pkg.sv | 13 +
 rtl/e2lp_rr_picker.sv | 31 +++
 rtl/e2lp_led_arbiter.sv | 78 +++++++
 tb/tb_e2lp_led_arbiter.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/e2lp_led_arbiter_pkg.sv
// e2lp_led_arbiter_pkg: shared constants and state encoding for the LED arbiter
// Contents: LED_WIDTH, DEFAULT_HOLD_CYCLES (board build hold time), state_t (IDLE/HOLD)
package e2lp_led_arbiter_pkg;

    localparam int LED_WIDTH = 8;
    localparam int DEFAULT_HOLD_CYCLES = 1024;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/e2lp_rr_picker.sv
// e2lp_rr_picker: combinational round-robin winner selection
// Ports: req (request vector), pointer (first index to consider),
//        valid (any request present), index (first asserted req at or after pointer, wrapping)
module e2lp_rr_picker #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] pointer,
    output logic                       valid,
    output logic [$clog2(NUM_REQ)-1:0] index
);

    localparam int IW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] rotated;
    logic [IW-1:0]      offset;

    // rotated[i] is the request i positions past the pointer; the lowest set bit wins
    always_comb begin
        rotated = '0;
        offset  = '0;
        for (int i = 0; i < NUM_REQ; i++)
            rotated[i] = req[(int'(pointer) + i) % NUM_REQ];
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (rotated[i])
                offset = IW'(i);
        valid = |req;
        index = IW'((int'(pointer) + int'(offset)) % NUM_REQ);
    end

endmodule

// File: rtl/e2lp_led_arbiter.sv
// e2lp_led_arbiter: round-robin sharing of the 8 board LEDs with a minimum visible hold time
// Ports: system_clock, system_reset (sync, active-high);
//        req / req_leds (per-requester level request and 8-bit bitmap);
//        ack (one-cycle grant pulse), o_Leds / o_Set (LED driver data and write strobe),
//        o_owner (last granted index), busy (high during the hold window)
module e2lp_led_arbiter
    import e2lp_led_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES
) (
    input  logic                           system_clock,
    input  logic                           system_reset,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [LED_WIDTH*NUM_REQ-1:0]   req_leds,
    output logic [NUM_REQ-1:0]             ack,
    output logic [LED_WIDTH-1:0]           o_Leds,
    output logic                           o_Set,
    output logic [$clog2(NUM_REQ)-1:0]     o_owner,
    output logic                           busy
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    state_t        state;
    logic [IW-1:0] pointer;
    logic [CW-1:0] counter;
    logic          pick_valid;
    logic [IW-1:0] pick_index;
    logic          grant;

    e2lp_rr_picker #(.NUM_REQ(NUM_REQ)) picker (
        .req     (req),
        .pointer (pointer),
        .valid   (pick_valid),
        .index   (pick_index)
    );

    // The o_Set cycle is the grant cycle itself; the hold countdown starts after it,
    // giving HOLD_CYCLES+1 cycles between Set pulses under continuous requests.
    assign grant = pick_valid && (state == IDLE || (!o_Set && counter == '0));

    always_ff @(posedge system_clock) begin
        if (system_reset) begin
            state   <= IDLE;
            o_Leds  <= '0;
            o_Set   <= 1'b0;
            ack     <= '0;
            o_owner <= '0;
            busy    <= 1'b0;
            pointer <= '0;
            counter <= '0;
        end else begin
            o_Set <= 1'b0;
            ack   <= '0;
            if (grant) begin
                o_Leds  <= req_leds[pick_index*LED_WIDTH +: LED_WIDTH];
                o_Set   <= 1'b1;
                ack     <= NUM_REQ'(1) << pick_index;
                o_owner <= pick_index;
                pointer <= (pick_index == IW'(NUM_REQ - 1)) ? '0 : pick_index + 1'b1;
                counter <= CW'(HOLD_CYCLES - 1);
                busy    <= (state == HOLD);
                state   <= HOLD;
            end else if (state == HOLD) begin
                if (o_Set)
                    busy <= 1'b1;
                else if (counter == '0) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end else
                    counter <= counter - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_e2lp_led_arbiter.sv
// tb_e2lp_led_arbiter: directed self-checking bench for e2lp_led_arbiter (NUM_REQ=4, HOLD_CYCLES=4)
module tb_e2lp_led_arbiter;

    logic        system_clock = 1'b0;
    logic        system_reset = 1'b1;
    logic [3:0]  req = '0;
    logic [31:0] req_leds = '0;
    logic [3:0]  ack;
    logic [7:0]  o_Leds;
    logic        o_Set;
    logic [1:0]  o_owner;
    logic        busy;
    int          checks = 0;
    int          errors = 0;

    e2lp_led_arbiter #(.NUM_REQ(4), .HOLD_CYCLES(4)) dut (
        .system_clock (system_clock),
        .system_reset (system_reset),
        .req          (req),
        .req_leds     (req_leds),
        .ack          (ack),
        .o_Leds       (o_Leds),
        .o_Set        (o_Set),
        .o_owner      (o_owner),
        .busy         (busy)
    );

    always #5 system_clock = ~system_clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge system_clock);
    endtask

    task automatic expect_grant(input string tag, input int idx, input logic [7:0] leds);
        check({tag, " set"}, 32'(o_Set), 32'd1);
        check({tag, " ack"}, 32'(ack), 32'(4'b0001 << idx));
        check({tag, " owner"}, 32'(o_owner), 32'(idx));
        check({tag, " leds"}, 32'(o_Leds), 32'(leds));
    endtask

    task automatic expect_quiet(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            step(1);
            check({tag, " no set"}, 32'(o_Set), 32'd0);
            check({tag, " no ack"}, 32'(ack), 32'd0);
        end
    endtask

    initial begin
        int rr_order[5] = '{0, 1, 2, 3, 0};
        logic [7:0] rr_data[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        step(2);
        check("reset set", 32'(o_Set), 32'd0);
        check("reset ack", 32'(ack), 32'd0);
        check("reset leds", 32'(o_Leds), 32'd0);
        check("reset owner", 32'(o_owner), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        system_reset = 1'b0;
        step(1);
        check("idle no set", 32'(o_Set), 32'd0);
        // round-robin: all four held, grants 0,1,2,3,0 five cycles apart
        req = 4'b1111;
        req_leds = 32'h44332211;
        for (int k = 0; k < 5; k++) begin
            if (k > 0)
                expect_quiet("rr gap", 4);
            step(1);
            expect_grant("rr", rr_order[k], rr_data[rr_order[k]]);
        end
        req = '0;
        step(5);
        check("rr idle busy", 32'(busy), 32'd0);
        // single request (pointer is 1)
        req = 4'b0010;
        req_leds = 32'h0000A500;
        step(1);
        expect_grant("single", 1, 8'hA5);
        check("single set busy", 32'(busy), 32'd0);
        req = '0;
        for (int i = 0; i < 4; i++) begin
            step(1);
            check("single busy", 32'(busy), 32'd1);
            check("single hold set", 32'(o_Set), 32'd0);
        end
        step(1);
        check("single idle busy", 32'(busy), 32'd0);
        check("single leds kept", 32'(o_Leds), 32'hA5);
        // rotation: pointer 2, req 0011 -> 0 then 1
        req = 4'b0011;
        req_leds = 32'h00002010;
        step(1);
        expect_grant("rot first", 0, 8'h10);
        req = 4'b0010;
        expect_quiet("rot gap", 4);
        step(1);
        expect_grant("rot second", 1, 8'h20);
        req = '0;
        step(5);
        // withdrawal: req[3] raised and dropped inside HOLD
        req = 4'b0100;
        req_leds = 32'h00770000;
        step(1);
        expect_grant("wd grant", 2, 8'h77);
        req = '0;
        expect_quiet("wd hold", 1);
        req = 4'b1000;
        req_leds = 32'h99000000;
        expect_quiet("wd raised", 2);
        req = '0;
        expect_quiet("wd dropped", 2);
        check("wd idle busy", 32'(busy), 32'd0);
        check("wd owner", 32'(o_owner), 32'd2);
        check("wd leds", 32'(o_Leds), 32'h77);
        // back-to-back: req[0] arrives in the counter==0 cycle (pointer is 3)
        req = 4'b1000;
        step(1);
        expect_grant("b2b first", 3, 8'h99);
        req = '0;
        expect_quiet("b2b hold", 4);
        check("b2b still busy", 32'(busy), 32'd1);
        req = 4'b0001;
        req_leds = 32'h000000C3;
        step(1);
        expect_grant("b2b second", 0, 8'hC3);
        req = '0;
        step(5);
        // reset inside HOLD with counter at 2 (pointer is 1 -> grant 1, pointer 2)
        req = 4'b0010;
        req_leds = 32'h00003C00;
        step(1);
        expect_grant("rst pre", 1, 8'h3C);
        req = '0;
        step(2);
        system_reset = 1'b1;
        step(1);
        check("rst hold set", 32'(o_Set), 32'd0);
        check("rst hold ack", 32'(ack), 32'd0);
        check("rst hold leds", 32'(o_Leds), 32'd0);
        check("rst hold busy", 32'(busy), 32'd0);
        check("rst hold owner", 32'(o_owner), 32'd0);
        // reset wins over a would-be grant
        req = 4'b0001;
        req_leds = 32'h00000001;
        step(1);
        check("rst grant set", 32'(o_Set), 32'd0);
        check("rst grant ack", 32'(ack), 32'd0);
        // pointer must be back at 0: 0110 grants 1, then 2 with 5A back-to-back
        system_reset = 1'b0;
        req = 4'b0110;
        req_leds = 32'h005A1E00;
        step(1);
        expect_grant("rst ptr", 1, 8'h1E);
        req = 4'b0100;
        expect_quiet("rst gap", 4);
        step(1);
        expect_grant("rst req2", 2, 8'h5A);
        req = '0;
        step(5);
        check("final busy", 32'(busy), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
